muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit; the responder on the stall side of the stage sequencer.
//  Accepts one operation per start strobe during EX and holds exBusy high while computing.
//  The stage sequencer freezes the stage counter until exBusy falls.
//  Result is held stable for the MA/WB stages.
// PARAMETERS
//  XLEN       32   operand/result width; only 32 is supported
//  CNT_W      5    iteration counter width, $clog2(XLEN)
// PORTS
//  CLK        in   1     single system clock, all state on posedge
//  RST        in   1     asynchronous, active-high reset
//  start      in   1     1-cycle request strobe; ignored unless state==IDLE or DONE
//  op         in   3     RV32M funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (0..7)
//  rs1        in   32    operand A, sampled on the start cycle only
//  rs2        in   32    operand B, sampled on the start cycle only
//  exBusy     out  1     stall request to the stage sequencer
//  done       out  1     1-cycle pulse: result valid
//  result     out  32    final value, held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, exBusy=0, done=0, result=0, counter=0, operand regs=0. Reset is legal at any time.
//  Reset mid-operation aborts the operation; no done pulse follows.
//  exBusy = (start & accept) | (state inside {PREP,CALC,FIX}); combinational so the start cycle already stalls.
//  FSM:
//   IDLE -> PREP on an accepted start; latch op, rs1, rs2.
//   PREP: take absolute values per signedness and record result sign. Check special cases:
//    - div by zero: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> rs1.
//    - DIV overflow (rs1=32'h8000_0000, rs2=-1): DIV -> 32'h8000_0000; REM -> 0.
//    A special case goes straight to DONE; otherwise PREP -> CALC.
//   CALC: XLEN iterations, counter 0..31.
//    - multiply: shift-add over a 64-bit accumulator.
//    - divide: restoring divide, 1 quotient bit per cycle.
//    counter==31 -> FIX.
//   FIX: two's-complement negate per the recorded sign. Select the low word (MUL) or the high word (MULH*).
//    Select quotient or remainder; the remainder sign follows the dividend. Then -> DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is accepted (DONE -> PREP).
//  Latency (start at cycle 0): normal done at cycle 35; special case done at cycle 2.
//  start while busy (PREP/CALC/FIX) is ignored, with no side effects.
//  All arithmetic is unsigned internally, on 33-bit partial remainders and a 64-bit product.
//  MULHSU: rs1 is signed, rs2 is unsigned.
//  result updates only on entry to DONE.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   - MUL* ops use a single-cycle 32x32 '*' product in PREP and skip CALC (PREP -> FIX).
//   - Multiply done at cycle 3. Divide is unchanged.
//  MULDIV_FAST_MUL_EN undefined: all ops are iterative as above.
// STRUCTURE
//  Package shrv32_muldiv_pkg holds:
//   - typedef enum logic[2:0] muldiv_op_e (OP_MUL..OP_REMU)
//   - typedef enum logic[2:0] muldiv_state_e (IDLE,PREP,CALC,FIX,DONE)
//   - localparam XLEN=32
//   - function is_div(op)
//  One sub-module, muldiv_div_step: combinational restoring-divide step.
//   - inputs: remainder[32:0], divisor[31:0], next dividend bit
//   - outputs: new remainder, quotient bit
//  The FSM, counter and multiply datapath live in muldiv_unit.
// TESTING
//  1. MUL rs1=7 rs2=-3 -> exBusy high on cycles 0..34, done at cycle 35, result=32'hFFFF_FFEB.
//  2. MULHU rs1=rs2=32'hFFFF_FFFF -> result=32'hFFFF_FFFE. MULH, same operands -> 0.
//  3. DIV rs1=-7 rs2=2 -> result=-3 (32'hFFFF_FFFD). REM, same operands -> -1.
//  4. DIVU rs1=5 rs2=0 -> done at cycle 2, result=32'hFFFF_FFFF. REMU, same operands -> 5.
//  5. DIV rs1=32'h8000_0000 rs2=-1 -> result=32'h8000_0000. REM, same operands -> 0.
//  6. start DIV, pulse start again at cycle 10 (ignored), then assert RST at cycle 20:
//     exBusy=0 and result=0 immediately; no done. A new MUL 3*4 after reset -> result=12.

Source files
------------

// File: rtl/shrv32_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// shrv32_muldiv_pkg
//   Shared types and helpers for the iterative RV32M multiply/divide unit.
//   - muldiv_op_e    : RV32M funct3 encoding (MUL..REMU)
//   - muldiv_state_e : sequencing states of muldiv_unit
//   - XLEN / CNT_W   : datapath width and iteration counter width
//   - is_div / rs1_signed / rs2_signed : op classification helpers
// ----------------------------------------------------------------------------
package shrv32_muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   // Counter value of the final CALC iteration.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
   endfunction

   // MUL is treated as unsigned: the low product word does not depend on
   // operand signedness, so no sign fix-up is needed for it.
   function automatic logic rs1_signed(input muldiv_op_e op);
      return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   endfunction

   function automatic logic rs2_signed(input muldiv_op_e op);
      return (op inside {OP_MULH, OP_DIV, OP_REM});
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// ----------------------------------------------------------------------------
// muldiv_div_step
//   One combinational step of a restoring divide: shift the next dividend bit
//   into the partial remainder, trial-subtract the divisor and keep the
//   difference only when it does not go negative.
// Ports
//   rem_i       [XLEN:0]   partial remainder before this step
//   divisor_i   [XLEN-1:0] divisor magnitude
//   dvd_bit_i              next dividend bit (MSB first)
//   rem_o       [XLEN:0]   partial remainder after this step
//   q_bit_o                quotient bit produced by this step
// ----------------------------------------------------------------------------
module muldiv_div_step
   import shrv32_muldiv_pkg::*;
(
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            dvd_bit_i,
   output logic [XLEN:0]   rem_o,
   output logic            q_bit_o
);

   logic [XLEN+1:0] shifted;

   assign shifted = {rem_i, dvd_bit_i};
   assign q_bit_o = (shifted >= {2'b00, divisor_i});
   // The remainder stays below the divisor, so the difference fits XLEN+1 bits.
   assign rem_o   = q_bit_o ? (XLEN+1)'(shifted - {2'b00, divisor_i})
                            : shifted[XLEN:0];

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. An operation is accepted
//   on a start strobe in IDLE or DONE; exBusy stalls the stage sequencer from
//   the start cycle until the result is ready. The result is held until the
//   next accepted start completes.
//   Sequence: PREP (magnitudes, sign, special cases) -> CALC (32 shift-add or
//   restoring-divide iterations) -> FIX (sign and word select) -> DONE.
// Ports
//   CLK                 system clock
//   RST                 asynchronous active-high reset
//   start               1-cycle request strobe
//   op      [2:0]       RV32M funct3
//   rs1/rs2 [XLEN-1:0]  operands, sampled on the accepted start cycle
//   exBusy              stall request (combinational)
//   done                1-cycle result-valid pulse
//   result  [XLEN-1:0]  final value
// Configuration
//   MULDIV_FAST_MUL_EN : multiplies use a single-cycle product in PREP and
//                        skip CALC. Undefined: all ops are iterative.
// ----------------------------------------------------------------------------
module muldiv_unit
   import shrv32_muldiv_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            exBusy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   muldiv_state_e     state_q;
   muldiv_op_e        op_q;
   logic [XLEN-1:0]   opa_q;     // raw rs1, then |rs1| from PREP on
   logic [XLEN-1:0]   opb_q;     // raw rs2, then |rs2| from PREP on
   logic [2*XLEN-1:0] acc_q;     // product, or {unused, dividend/quotient}
   logic [XLEN:0]     rem_q;     // partial remainder
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q;     // negate the final result in FIX
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              div_zero;
   logic              div_ovf;
   logic              res_neg_d;
   logic [XLEN-1:0]   special_d;
   logic [2*XLEN-1:0] fix_prod;
   logic [XLEN-1:0]   fix_result_d;
   logic [XLEN:0]     mul_sum_d;
   logic [2*XLEN-1:0] mul_acc_d;
   logic [XLEN:0]     rem_d;
   logic              q_bit_d;
   logic [2*XLEN-1:0] div_acc_d;

   assign accept = start & ((state_q == IDLE) | (state_q == DONE));
   assign exBusy = accept | (state_q inside {PREP, CALC, FIX});
   assign done   = done_q;
   assign result = result_q;

   // Shift-add multiply: multiplier sits in the low word and is consumed
   // LSB first; the multiplicand is added into the high word before shifting.
   assign mul_sum_d = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opa_q & {XLEN{acc_q[0]}}};
   assign mul_acc_d = {mul_sum_d, acc_q[XLEN-1:1]};

   muldiv_div_step u_div_step (
      .rem_i     (rem_q),
      .divisor_i (opb_q),
      .dvd_bit_i (acc_q[XLEN-1]),
      .rem_o     (rem_d),
      .q_bit_o   (q_bit_d)
   );

   // Dividend bits leave at the top of the low word while quotient bits
   // enter at the bottom, so the low word ends up holding the quotient.
   assign div_acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit_d};

   always_comb begin
      a_neg    = rs1_signed(op_q) & opa_q[XLEN-1];
      b_neg    = rs2_signed(op_q) & opb_q[XLEN-1];
      abs_a    = a_neg ? -opa_q : opa_q;
      abs_b    = b_neg ? -opb_q : opb_q;
      div_zero = is_div(op_q) && (opb_q == '0);
      div_ovf  = (op_q inside {OP_DIV, OP_REM}) &&
                 (opa_q == {1'b1, {(XLEN-1){1'b0}}}) && (opb_q == '1);

      res_neg_d = 1'b0;
      case (op_q)
         OP_MULH, OP_MULHSU, OP_DIV: res_neg_d = a_neg ^ b_neg;
         OP_REM:                     res_neg_d = a_neg;   // remainder follows dividend
         default:                    res_neg_d = 1'b0;
      endcase

      special_d = '0;
      if (div_zero) begin
         special_d = (op_q inside {OP_DIV, OP_DIVU}) ? '1 : opa_q;
      end else if (div_ovf) begin
         special_d = (op_q == OP_DIV) ? opa_q : '0;
      end

      // Negating the full product also yields the negated quotient in the
      // low word, so one negator serves both multiply and divide.
      fix_prod = neg_q ? -acc_q : acc_q;
      fix_result_d = fix_prod[XLEN-1:0];
      case (op_q)
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result_d = fix_prod[2*XLEN-1:XLEN];
         OP_REM, OP_REMU: fix_result_d = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
         default:         fix_result_d = fix_prod[XLEN-1:0];
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= PREP;
                  op_q    <= muldiv_op_e'(op);
                  opa_q   <= rs1;
                  opb_q   <= rs2;
               end else begin
                  state_q <= IDLE;
               end
            end
            PREP: begin
               neg_q <= res_neg_d;
               cnt_q <= '0;
               opa_q <= abs_a;
               opb_q <= abs_b;
               if (div_zero || div_ovf) begin
                  result_q <= special_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else if (is_div(op_q)) begin
                  acc_q   <= {{XLEN{1'b0}}, abs_a};
                  rem_q   <= '0;
                  state_q <= CALC;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_q   <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
                  state_q <= FIX;
`else
                  acc_q   <= {{XLEN{1'b0}}, abs_b};
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               if (is_div(op_q)) begin
                  acc_q <= div_acc_d;
                  rem_q <= rem_d;
               end else begin
                  acc_q <= mul_acc_d;
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               result_q <= fix_result_d;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        exBusy;
   logic        done;
   logic [31:0] result;

   muldiv_unit dut (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .exBusy (exBusy),
      .done   (done),
      .result (result)
   );

   typedef struct {
      logic [31:0] res;
      int          t;
      int          lat;
      logic [2:0]  op;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   ntx      = 0;
   int   t_last   = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   // Reference model: RV32M semantics from plain 64-bit / integer arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb_l;
      longint      ub;
      longint      p;
      logic [63:0] up;
      int          ia;
      int          ib;
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      ub   = longint'({32'h0, b});
      ia   = a;
      ib   = b;
      case (o)
         3'd0: begin p = sa * sb_l; return p[31:0]; end
         3'd1: begin p = sa * sb_l; return p[63:32]; end
         3'd2: begin p = sa * ub;   return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o >= 3'd4) begin
         if (b == 32'h0) return 2;
         if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
         return 35;
      end
`ifdef MULDIV_FAST_MUL_EN
      return 3;
`else
      return 35;
`endif
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Called #1 after a rising edge; drives the strobe for the current cycle.
   task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res);
      exp_t e;
      start = 1'b1;
      op    = o;
      rs1   = a;
      rs2   = b;
      e.res = exp_res;
      e.t   = cyc;
      e.lat = exp_lat(o, a, b);
      e.op  = o;
      sb.push_back(e);
      t_last = cyc;
   endtask

   // Operands are scrambled after the start cycle: they must not be re-sampled.
   task automatic end_start();
      start = 1'b0;
      op    = 3'($urandom_range(0, 7));
      rs1   = $urandom;
      rs2   = $urandom;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
      drive_start(o, a, b, exp_res);
      @(posedge CLK); #1;
      end_start();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=pending_%0d required=pending_0", sb.size());
         sb.delete();
      end
   endtask

   task automatic ignored_start();
      start = 1'b1;
      op    = 3'($urandom_range(0, 7));
      rs1   = $urandom;
      rs2   = $urandom;
      @(posedge CLK); #1;
      end_start();
   endtask

   // Monitor: pops the scoreboard whenever the unit signals a result.
   always @(negedge CLK) begin
      if (!RST && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done_high required=no_done result=%h", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("latency", 32'(cyc - e.t), 32'(e.lat));
            ntx++;
            $display("txn %0d op=%0d result=%h expected=%h latency=%0d", ntx, e.op, result, e.res, cyc - e.t);
         end
      end
   end

   logic [2:0]  d_op [8] = '{3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd4};
   logic [31:0] d_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_r  [8] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'd5, 32'h0, 32'h8000_0000};

   initial begin
      int          busy_bad;
      int          t0;
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;

      RST   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      rs1   = 32'h0;
      rs2   = 32'h0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_exBusy", {31'h0, exBusy}, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);
      chk("reset_result", result, 32'h0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // MUL 7 * -3 with the stall window checked cycle by cycle.
      drive_start(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      busy_bad = 0;
      for (int j = 0; j <= 35; j++) begin
         @(negedge CLK);
         if (exBusy !== (j <= 34)) busy_bad++;
         @(posedge CLK); #1;
         if (j == 0) end_start();
      end
      chk("busy_window_errors", 32'(busy_bad), 32'h0);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         issue(d_op[i], d_a[i], d_b[i], d_r[i]);
         wait_idle();
      end

      // Abort a divide by reset after an ignored start.
      issue(3'd4, 32'd1000, 32'd7, 32'd142);
      t0 = t_last;
      while (cyc < t0 + 10) begin @(posedge CLK); #1; end
      ignored_start();
      while (cyc < t0 + 20) begin @(posedge CLK); #1; end
      RST = 1'b1;
      #1;
      chk("abort_exBusy", {31'h0, exBusy}, 32'h0);
      chk("abort_result", result, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      sb.delete();
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (40) begin @(posedge CLK); #1; end
      issue(3'd0, 32'd3, 32'd4, 32'd12);
      wait_idle();

      // Randomised traffic: back-to-back starts in DONE and ignored starts while busy.
      for (int i = 0; i < 150; i++) begin
         o   = 3'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         lat = exp_lat(o, a, b);
         issue(o, a, b, ref_model(o, a, b));
         t0 = t_last;
         if (lat == 35 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 30)) begin @(posedge CLK); #1; end
            ignored_start();
         end
         if (i < 149 && $urandom_range(0, 3) == 0) begin
            while (cyc < t0 + lat) begin @(posedge CLK); #1; end
         end else begin
            wait_idle();
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
         end
      end
      wait_idle();
      repeat (5) @(posedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
